// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, latencies.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam int LAT_ADD_DEF   = 2;
  localparam int LAT_LOGIC_DEF = 1;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
  } req_t;

  // EXEC cycle count for an opcode; anything with SELECT[2] set is illegal
  // and finishes in a single cycle.
  function automatic logic [CNT_W-1:0] op_lat(input logic [2:0] sel,
                                              input int lat_add,
                                              input int lat_logic);
    logic [CNT_W-1:0] lat;
    lat = CNT_W'(1);
    case (sel)
      OP_ADD:                lat = CNT_W'(lat_add);
      OP_FWD, OP_AND, OP_OR: lat = CNT_W'(lat_logic);
      default:               lat = CNT_W'(1);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, the pointer
// breaks ties when both request.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant from the valid pair and the priority pointer.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU. One operation is
// in flight at a time: accept in IDLE, wait the opcode latency in EXEC, hold
// the response in RESP until the owner takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int LAT_ADD   = LAT_ADD_DEF,
  parameter int LAT_LOGIC = LAT_LOGIC_DEF
) (
  input  logic       CLK,
  input  logic       RESET,

  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [7:0] REQ0_DATA1,
  input  logic [7:0] REQ0_DATA2,
  input  logic [2:0] REQ0_SELECT,
  output logic       RSP0_VALID,
  input  logic       RSP0_READY,
  output logic [7:0] RSP0_RESULT,
  output logic       RSP0_ZERO,
  output logic       RSP0_ERR,

  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [7:0] REQ1_DATA1,
  input  logic [7:0] REQ1_DATA2,
  input  logic [2:0] REQ1_SELECT,
  output logic       RSP1_VALID,
  input  logic       RSP1_READY,
  output logic [7:0] RSP1_RESULT,
  output logic       RSP1_ZERO,
  output logic       RSP1_ERR,

  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO,

  output logic       BUSY
);

  state_t           state_q, state_d;
  logic             ptr_q;
  logic             owner_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;
  req_t             alu_q;

  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic [1:0]       rsp_ready;
  req_t [1:0]       req;
  req_t             win;

  logic [1:0][7:0]  rsp_result_q;
  logic [1:0]       rsp_zero_q;
  logic [1:0]       rsp_err_q;

  logic             accept;
  logic             capture;

  assign req_valid = {REQ1_VALID, REQ0_VALID};
  assign rsp_ready = {RSP1_READY, RSP0_READY};
  assign req[0]    = '{d1: REQ0_DATA1, d2: REQ0_DATA2, sel: REQ0_SELECT};
  assign req[1]    = '{d1: REQ1_DATA1, d2: REQ1_DATA2, sel: REQ1_SELECT};
  assign win       = grant[1] ? req[1] : req[0];

  rr_arb2 u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the accept/capture strobes driving the datapath.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers, latency counter and round-robin pointer. Illegal
  // opcodes leave the ALU-facing registers untouched so the ALU sees no
  // input change for them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      alu_q   <= '0;
    end else if (accept) begin
      owner_q <= grant[1];
      ptr_q   <= ~grant[1];
      ill_q   <= win.sel[2];
      cnt_q   <= op_lat(win.sel, LAT_ADD, LAT_LOGIC);
      if (!win.sel[2]) alu_q <= win;
    end else if (state_q == ST_EXEC) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Per-requester response registers; they keep the last capture so a
  // requester can still read its result after taking it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
    end else if (capture) begin
      rsp_result_q[owner_q] <= ill_q ? 8'h00 : ALU_RESULT;
      rsp_zero_q[owner_q]   <= ill_q ? 1'b1  : ALU_ZERO;
      rsp_err_q[owner_q]    <= ill_q;
    end
  end

  assign REQ0_READY  = (state_q == ST_IDLE) & grant[0];
  assign REQ1_READY  = (state_q == ST_IDLE) & grant[1];
  assign RSP0_VALID  = (state_q == ST_RESP) & ~owner_q;
  assign RSP1_VALID  = (state_q == ST_RESP) &  owner_q;
  assign RSP0_RESULT = rsp_result_q[0];
  assign RSP0_ZERO   = rsp_zero_q[0];
  assign RSP0_ERR    = rsp_err_q[0];
  assign RSP1_RESULT = rsp_result_q[1];
  assign RSP1_ZERO   = rsp_zero_q[1];
  assign RSP1_ERR    = rsp_err_q[1];
  assign ALU_DATA1   = alu_q.d1;
  assign ALU_DATA2   = alu_q.d2;
  assign ALU_SELECT  = alu_q.sel;
  assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0_VALID, REQ0_READY, RSP0_VALID, RSP0_READY, RSP0_ZERO, RSP0_ERR;
  logic [7:0] REQ0_DATA1, REQ0_DATA2, RSP0_RESULT;
  logic [2:0] REQ0_SELECT;
  logic       REQ1_VALID, REQ1_READY, RSP1_VALID, RSP1_READY, RSP1_ZERO, RSP1_ERR;
  logic [7:0] REQ1_DATA1, REQ1_DATA2, RSP1_RESULT;
  logic [2:0] REQ1_SELECT;
  logic [7:0] ALU_DATA1, ALU_DATA2, ALU_RESULT;
  logic [2:0] ALU_SELECT;
  logic       ALU_ZERO, BUSY;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 CLK = ~CLK;

  // External ALU model.
  always_comb begin
    ALU_RESULT = 8'h00;
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA1;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
    ALU_ZERO = (ALU_RESULT == 8'h00);
  end

  alu_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_DATA1(REQ0_DATA1),
    .REQ0_DATA2(REQ0_DATA2), .REQ0_SELECT(REQ0_SELECT), .RSP0_VALID(RSP0_VALID),
    .RSP0_READY(RSP0_READY), .RSP0_RESULT(RSP0_RESULT), .RSP0_ZERO(RSP0_ZERO),
    .RSP0_ERR(RSP0_ERR),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_DATA1(REQ1_DATA1),
    .REQ1_DATA2(REQ1_DATA2), .REQ1_SELECT(REQ1_SELECT), .RSP1_VALID(RSP1_VALID),
    .RSP1_READY(RSP1_READY), .RSP1_RESULT(RSP1_RESULT), .RSP1_ZERO(RSP1_ZERO),
    .RSP1_ERR(RSP1_ERR),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    steps(2);
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b0;
    REQ0_VALID = 0; REQ0_DATA1 = 0; REQ0_DATA2 = 0; REQ0_SELECT = 0; RSP0_READY = 0;
    REQ1_VALID = 0; REQ1_DATA1 = 0; REQ1_DATA2 = 0; REQ1_SELECT = 0; RSP1_READY = 0;
    @(negedge CLK);
    do_reset();

    // Reset state.
    chk("rst_busy",   BUSY,        0);
    chk("rst_rdy0",   REQ0_READY,  0);
    chk("rst_rdy1",   REQ1_READY,  0);
    chk("rst_rv0",    RSP0_VALID,  0);
    chk("rst_rv1",    RSP1_VALID,  0);
    chk("rst_res0",   RSP0_RESULT, 0);
    chk("rst_zero0",  RSP0_ZERO,   0);
    chk("rst_aluD1",  ALU_DATA1,   0);
    chk("rst_aluSel", ALU_SELECT,  0);

    // REQ0 ADD 5+3 alone, LAT 2.
    REQ0_VALID = 1; REQ0_DATA1 = 8'h05; REQ0_DATA2 = 8'h03; REQ0_SELECT = 3'b001;
    #1;
    chk("add_rdy0", REQ0_READY, 1);
    chk("add_rdy1", REQ1_READY, 0);
    step();                       // t0
    REQ0_VALID = 0;
    chk("add_busy",  BUSY,       1);
    chk("add_rdy0x", REQ0_READY, 0);
    chk("add_aluD1", ALU_DATA1,  8'h05);
    chk("add_aluSl", ALU_SELECT, 3'b001);
    chk("add_rv_e1", RSP0_VALID, 0);
    step();                       // t0+1
    chk("add_rv_e2", RSP0_VALID, 0);
    step();                       // t0+2 capture
    chk("add_rv",    RSP0_VALID,  1);
    chk("add_rv1",   RSP1_VALID,  0);
    chk("add_res",   RSP0_RESULT, 8'h08);
    chk("add_zero",  RSP0_ZERO,   0);
    chk("add_err",   RSP0_ERR,    0);
    RSP0_READY = 1;
    step();
    RSP0_READY = 0;
    chk("add_done_rv",  RSP0_VALID,  0);
    chk("add_done_bsy", BUSY,        0);
    chk("add_hold_res", RSP0_RESULT, 8'h08);

    // Both valid from reset; REQ0 first, REQ1 waits through a slow RSP0 ack.
    do_reset();
    REQ0_VALID = 1; REQ0_DATA1 = 8'h10; REQ0_DATA2 = 8'h20; REQ0_SELECT = 3'b001;
    REQ1_VALID = 1; REQ1_DATA1 = 8'h0C; REQ1_DATA2 = 8'h30; REQ1_SELECT = 3'b011;
    #1;
    chk("rr_rdy0", REQ0_READY, 1);
    chk("rr_rdy1", REQ1_READY, 0);
    step();
    REQ0_VALID = 0;
    chk("rr_exec_rdy1", REQ1_READY, 0);
    steps(2);
    chk("rr_rv0",  RSP0_VALID,  1);
    chk("rr_rv1",  RSP1_VALID,  0);
    chk("rr_res0", RSP0_RESULT, 8'h30);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_rv0",  RSP0_VALID,  1);
      chk("hold_res0", RSP0_RESULT, 8'h30);
      chk("hold_busy", BUSY,        1);
      chk("hold_rdy1", REQ1_READY,  0);
    end
    RSP0_READY = 1;
    step();
    RSP0_READY = 0;
    chk("rr_idle_rdy1", REQ1_READY, 1);
    step();
    REQ1_VALID = 0;
    step();
    chk("rr_rv1b",   RSP1_VALID,  1);
    chk("rr_rv0b",   RSP0_VALID,  0);
    chk("rr_res1",   RSP1_RESULT, 8'h3C);
    chk("rr_zero1",  RSP1_ZERO,   0);
    chk("rr_keep0",  RSP0_RESULT, 8'h30);
    RSP1_READY = 1;
    step();
    RSP1_READY = 0;

    // REQ1 AND F0&0F, LAT 1, pointer favours 0 but only REQ1 asks.
    REQ1_VALID = 1; REQ1_DATA1 = 8'hF0; REQ1_DATA2 = 8'h0F; REQ1_SELECT = 3'b010;
    #1;
    chk("and_rdy1", REQ1_READY, 1);
    step();
    REQ1_VALID = 0;
    chk("and_rv_e", RSP1_VALID, 0);
    step();
    chk("and_rv",   RSP1_VALID,  1);
    chk("and_res",  RSP1_RESULT, 8'h00);
    chk("and_zero", RSP1_ZERO,   1);
    chk("and_err",  RSP1_ERR,    0);
    RSP1_READY = 1;
    step();
    RSP1_READY = 0;

    // Illegal opcode from REQ0: ALU inputs stay as the AND left them.
    REQ0_VALID = 1; REQ0_DATA1 = 8'h77; REQ0_DATA2 = 8'h11; REQ0_SELECT = 3'b101;
    step();
    REQ0_VALID = 0;
    chk("ill_aluSel", ALU_SELECT, 3'b010);
    chk("ill_aluD1",  ALU_DATA1,  8'hF0);
    chk("ill_rv_e",   RSP0_VALID, 0);
    step();
    chk("ill_rv",     RSP0_VALID,  1);
    chk("ill_err",    RSP0_ERR,    1);
    chk("ill_res",    RSP0_RESULT, 8'h00);
    chk("ill_zero",   RSP0_ZERO,   1);
    chk("ill_aluSl2", ALU_SELECT,  3'b010);
    RSP0_READY = 1;
    step();
    RSP0_READY = 0;

    // Reset while in EXEC aborts; a fresh request then runs normally.
    REQ0_VALID = 1; REQ0_DATA1 = 8'h01; REQ0_DATA2 = 8'h01; REQ0_SELECT = 3'b001;
    step();
    REQ0_VALID = 0;
    chk("abt_busy_pre", BUSY, 1);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    chk("abt_busy", BUSY,        0);
    chk("abt_rv0",  RSP0_VALID,  0);
    chk("abt_res0", RSP0_RESULT, 0);
    chk("abt_alu",  ALU_DATA1,   0);
    step();
    chk("abt_rv0b", RSP0_VALID,  0);
    REQ1_VALID = 1; REQ1_DATA1 = 8'h5A; REQ1_DATA2 = 8'h00; REQ1_SELECT = 3'b000;
    #1;
    chk("new_rdy1", REQ1_READY, 1);
    step();
    REQ1_VALID = 0;
    step();
    chk("new_rv1",  RSP1_VALID,  1);
    chk("new_res1", RSP1_RESULT, 8'h5A);
    chk("new_rv0",  RSP0_VALID,  0);
    RSP1_READY = 1;
    step();
    RSP1_READY = 0;
    chk("new_idle", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
